axi_hsci_axil_regif: RTL
========================

Name: axi_hsci_axil_regif

Overview:
- AXI4-Lite slave front end for the axi_hsci register space.
- Consumes an axi4_lite interface bundle through its slave modport.
- Converts each AXI4-Lite transaction into a single-cycle request on a simple word-addressed register bus (up_* request/ack), then returns the AXI response.
- Write and read paths are independent FSMs; each path has a no-ack timeout that returns SLVERR.

Parameters:
- ADDR_WIDTH, 32, width of s_axi awaddr/araddr.
- DATA_WIDTH, 32, AXI and register data width; must be 32.
- UP_ADDR_WIDTH, 14, word-address width on the register bus.
- TIMEOUT_CYCLES, 31, WAIT-state cycles without ack before SLVERR; range 1..255.

Ports:
- s_axi_aclk  input  1  sole clock.
- s_axi_aresetn  input  1  synchronous active-low reset.
- s_axi  interface  axi4_lite.slave (DATA_WIDTH, ADDR_WIDTH)  AXI4-Lite slave port.
- up_wreq  output  1  write request pulse, 1 cycle.
- up_waddr  output  UP_ADDR_WIDTH  write word address.
- up_wdata  output  32  write data.
- up_wstrb  output  4  write byte strobes.
- up_wack  input  1  write acknowledge.
- up_rreq  output  1  read request pulse, 1 cycle.
- up_raddr  output  UP_ADDR_WIDTH  read word address.
- up_rdata  input  32  read data, valid with up_rack.
- up_rack  input  1  read acknowledge.

Behaviour:
- Reset: all state is cleared on the rising edge of s_axi_aclk while s_axi_aresetn=0.
  - All s_axi outputs are 0: awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata.
  - All up_* outputs are 0.
  - Both FSMs go to IDLE; timeout counters clear.
- Reset mid-operation: abandon the transaction. No response is issued and no further up_*req is issued for it.
- Address mapping:
  - up_waddr = awaddr[UP_ADDR_WIDTH+1:2]; up_raddr = araddr[UP_ADDR_WIDTH+1:2].
  - awprot and arprot are ignored.
  - Address bits [1:0] are ignored.
- Write FSM states: W_IDLE, W_REQ, W_WAIT, W_RESP.
  - W_IDLE:
    - awready=1 until an AW beat is latched; wready=1 until a W beat is latched.
    - AW and W are accepted in either order or in the same cycle; each handshake is awvalid&awready (resp. wvalid&wready).
    - Once both are latched, go to W_REQ on the next edge. awready and wready are 0 from that point.
  - W_REQ: up_wreq=1 for exactly one cycle with up_waddr/up_wdata/up_wstrb driven from the latched beats; go to W_WAIT.
  - W_WAIT:
    - Counter increments each cycle.
    - up_wack=1: bresp=2'b00, go to W_RESP.
    - Counter reaches TIMEOUT_CYCLES with no ack: bresp=2'b10, go to W_RESP.
    - An ack on the same cycle as the final count wins, giving OKAY.
  - W_RESP: bvalid=1 and held stable until bready=1; then W_IDLE and clear the latched flags.
  - Latency: the AW/W handshakes complete at cycle N, so up_wreq is asserted at N+1. An ack at cycle A gives bvalid at A+1.
- Read FSM states: R_IDLE, R_REQ, R_WAIT, R_RESP.
  - R_IDLE: arready=1; on arvalid&arready latch araddr and go to R_REQ.
  - R_REQ: up_rreq pulse for 1 cycle; go to R_WAIT.
  - R_WAIT:
    - up_rack=1: latch rdata=up_rdata, rresp=2'b00.
    - Timeout: rdata=0, rresp=2'b10.
    - Go to R_RESP.
  - R_RESP: rvalid=1 with rdata/rresp held stable until rready=1; then R_IDLE.
  - Latency: AR handshake at N gives up_rreq at N+1; rack at A gives rvalid at A+1.
- Acks outside the WAIT states (including late acks after a timeout) are ignored.
- Acks are only sampled from the cycle after the req pulse.
- Read and write paths run concurrently with no mutual blocking; the register bus must tolerate simultaneous up_wreq and up_rreq.
- One outstanding transaction per direction; no pipelining.

Test Plan:
- AW+W in same cycle, awaddr=0x0000_0010, wdata=0xA5A5_1234, wstrb=0xF, ack 2 cycles after wreq -> up_wreq one cycle with up_waddr=4; bvalid 3 cycles after wreq, bresp=0.
- W beat 3 cycles before AW -> wready drops after W handshake; up_wreq only the cycle after the AW handshake; wstrb=0x3 forwarded unchanged.
- Read araddr=0x20, rack with up_rdata=0xCAFE_F00D, rready low 4 cycles -> up_raddr=8; rvalid/rdata stable until rready; rresp=0.
- No ack, TIMEOUT_CYCLES=31 -> bvalid with bresp=2'b10; read case rdata=0, rresp=2'b10; a later stray ack causes no extra response.
- Simultaneous write and read to different addresses -> up_wreq and up_rreq in the same cycle; both responses return correctly.
- s_axi_aresetn low for 1 cycle while in W_WAIT -> bvalid stays 0; awready/wready=1 and arready=1 the cycle after reset release.

Source files
------------

// File: rtl/axi_hsci_axil_regif_if.sv
// AXI4-Lite bundle carrying the axi_hsci register traffic.
// The slave modport is the view taken by the register front end.
interface axi4_lite #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_hsci_axil_regif.sv
// AXI4-Lite slave that turns each transaction into a one-cycle up_* register
// bus request, with independent write/read FSMs and a no-ack SLVERR timeout.
//
// state  | meaning
// W_IDLE | collecting AW and W beats (either order)
// W_REQ  | up_wreq pulse with latched address/data/strobes
// W_WAIT | waiting for up_wack, counting down to timeout
// W_RESP | bvalid held until bready
// R_IDLE | arready high, waiting for AR beat
// R_REQ  | up_rreq pulse with latched address
// R_WAIT | waiting for up_rack, counting down to timeout
// R_RESP | rvalid/rdata/rresp held until rready
module axi_hsci_axil_regif #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int UP_ADDR_WIDTH  = 14,
    parameter int TIMEOUT_CYCLES = 31
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_aresetn,
    axi4_lite.slave                  s_axi,
    output logic                     up_wreq,
    output logic [UP_ADDR_WIDTH-1:0] up_waddr,
    output logic [31:0]              up_wdata,
    output logic [3:0]               up_wstrb,
    input  logic                     up_wack,
    output logic                     up_rreq,
    output logic [UP_ADDR_WIDTH-1:0] up_raddr,
    input  logic [31:0]              up_rdata,
    input  logic                     up_rack
);
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // Down-counter preset so that TIMEOUT_CYCLES WAIT cycles elapse before SLVERR.
    localparam logic [7:0] TO_LOAD     = 8'(TIMEOUT_CYCLES - 1);

    w_state_t                 w_state, w_state_n;
    r_state_t                 r_state, r_state_n;
    logic                     aw_got, aw_got_n, w_got, w_got_n;
    logic                     aw_hs, w_hs, ar_hs;
    logic [7:0]               w_cnt, w_cnt_n, r_cnt, r_cnt_n;
    logic                     awready_q, awready_n, wready_q, wready_n;
    logic                     bvalid_q, bvalid_n, arready_q, arready_n;
    logic                     rvalid_q, rvalid_n;
    logic [1:0]               bresp_q, bresp_n, rresp_q, rresp_n;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_n;
    logic [UP_ADDR_WIDTH-1:0] waddr_q, raddr_q;
    logic [31:0]              wdata_q;
    logic [3:0]               wstrb_q;
    logic                     unused_bits;

    assign aw_hs = s_axi.awvalid & awready_q;
    assign w_hs  = s_axi.wvalid & wready_q;
    assign ar_hs = s_axi.arvalid & arready_q;

    always_comb begin
        w_state_n = w_state;
        aw_got_n  = aw_got | aw_hs;
        w_got_n   = w_got | w_hs;
        w_cnt_n   = w_cnt;
        bresp_n   = bresp_q;
        case (w_state)
            W_IDLE: if (aw_got_n && w_got_n) w_state_n = W_REQ;
            W_REQ: begin
                w_state_n = W_WAIT;
                w_cnt_n   = TO_LOAD;
            end
            W_WAIT: begin
                if (up_wack) begin
                    bresp_n   = RESP_OKAY;
                    w_state_n = W_RESP;
                end else if (w_cnt == 8'd0) begin
                    bresp_n   = RESP_SLVERR;
                    w_state_n = W_RESP;
                end else begin
                    w_cnt_n = w_cnt - 8'd1;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_n = W_IDLE;
                    aw_got_n  = 1'b0;
                    w_got_n   = 1'b0;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
        awready_n = (w_state_n == W_IDLE) && !aw_got_n;
        wready_n  = (w_state_n == W_IDLE) && !w_got_n;
        bvalid_n  = (w_state_n == W_RESP);
    end

    always_comb begin
        r_state_n = r_state;
        r_cnt_n   = r_cnt;
        rresp_n   = rresp_q;
        rdata_n   = rdata_q;
        case (r_state)
            R_IDLE: if (ar_hs) r_state_n = R_REQ;
            R_REQ: begin
                r_state_n = R_WAIT;
                r_cnt_n   = TO_LOAD;
            end
            R_WAIT: begin
                if (up_rack) begin
                    rdata_n   = up_rdata;
                    rresp_n   = RESP_OKAY;
                    r_state_n = R_RESP;
                end else if (r_cnt == 8'd0) begin
                    rdata_n   = '0;
                    rresp_n   = RESP_SLVERR;
                    r_state_n = R_RESP;
                end else begin
                    r_cnt_n = r_cnt - 8'd1;
                end
            end
            R_RESP: if (s_axi.rready) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
        arready_n = (r_state_n == R_IDLE);
        rvalid_n  = (r_state_n == R_RESP);
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            w_cnt     <= '0;
            r_cnt     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            raddr_q   <= '0;
        end else begin
            w_state   <= w_state_n;
            r_state   <= r_state_n;
            aw_got    <= aw_got_n;
            w_got     <= w_got_n;
            w_cnt     <= w_cnt_n;
            r_cnt     <= r_cnt_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rresp_q   <= rresp_n;
            rdata_q   <= rdata_n;
            if (aw_hs) waddr_q <= s_axi.awaddr[UP_ADDR_WIDTH+1:2];
            if (w_hs) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
            if (ar_hs) raddr_q <= s_axi.araddr[UP_ADDR_WIDTH+1:2];
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    assign up_wreq  = (w_state == W_REQ);
    assign up_waddr = waddr_q;
    assign up_wdata = wdata_q;
    assign up_wstrb = wstrb_q;
    assign up_rreq  = (r_state == R_REQ);
    assign up_raddr = raddr_q;

    // Protection and byte-offset address bits carry no meaning here.
    assign unused_bits = ^{s_axi.awaddr, s_axi.araddr, s_axi.awprot, s_axi.arprot};
endmodule
